// File: rtl/instr_field_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_field_encoder
// Purpose  : Packs opcode / register / flag fields into a 16-bit instruction
//            word {op, ra, rb, rc}, rejects field sets whose flag does not
//            match rc[2] (the flag aliases word bit 2), and buffers accepted
//            words in a DEPTH-entry FIFO with valid/ready on both sides.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            in_valid/in_ready - upstream handshake for a field set
//            in_op/ra/rb/rc    - 4-bit fields -> word[15:12]/[11:8]/[7:4]/[3:0]
//            in_flag           - flag bit, must equal in_rc[2]
//            out_valid/out_ready/out_word - downstream handshake + head word
//            err_pulse         - one-cycle pulse after a rejected field set
//            err_count         - saturating count of rejected field sets
//            level             - FIFO occupancy, 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module instr_field_encoder #(
    parameter int DEPTH = 4,
    parameter int LVLW  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [3:0]      in_ra,
    input  logic [3:0]      in_rb,
    input  logic [3:0]      in_rc,
    input  logic            in_flag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     out_word,
    output logic            err_pulse,
    output logic [7:0]      err_count,
    output logic [LVLW-1:0] level
);

    localparam int PTRW = $clog2(DEPTH);

    localparam logic [LVLW-1:0] c_lvl_one      = LVLW'(1);
    localparam logic [LVLW-1:0] c_lvl_depth    = LVLW'(DEPTH);
    localparam logic [LVLW-1:0] c_lvl_depth_m1 = LVLW'(DEPTH - 1);
    localparam logic [PTRW-1:0] c_ptr_one      = PTRW'(1);
    localparam logic [7:0]      c_err_max      = 8'hFF;

    // Occupancy state, kept in lock-step with r_level so that the handshake
    // outputs come straight from a small registered encoding.
    localparam logic [1:0] c_st_empty   = 2'd0;
    localparam logic [1:0] c_st_partial = 2'd1;
    localparam logic [1:0] c_st_full    = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [LVLW-1:0] r_level;
    logic [LVLW-1:0] w_level_nxt;
    logic [PTRW-1:0] r_wr_ptr;
    logic [PTRW-1:0] r_rd_ptr;
    logic [15:0]     r_mem [DEPTH];
    logic            r_err_pulse;
    logic [7:0]      r_err_count;

    logic            w_in_ready;
    logic            w_out_valid;
    logic            w_acc;
    logic            w_flag_ok;
    logic            w_push;
    logic            w_reject;
    logic            w_pop;
    logic [15:0]     w_word;

    // ------------------------------------------------------------------
    // Handshake and field checking
    // ------------------------------------------------------------------
    assign w_in_ready  = (r_state != c_st_full);
    assign w_out_valid = (r_state != c_st_empty);

    assign w_word    = {in_op, in_ra, in_rb, in_rc};
    assign w_acc     = in_valid & w_in_ready;
    assign w_flag_ok = (in_flag == in_rc[2]);
    assign w_push    = w_acc & w_flag_ok;
    assign w_reject  = w_acc & ~w_flag_ok;
    assign w_pop     = w_out_valid & out_ready;

    // ------------------------------------------------------------------
    // Occupancy state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_empty;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + c_lvl_one;
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - c_lvl_one;
        end

        case (r_state)
            c_st_empty: begin
                if (w_push) begin
                    w_state_nxt = c_st_partial;
                end
            end
            c_st_partial: begin
                if (w_push && !w_pop && (r_level == c_lvl_depth_m1)) begin
                    w_state_nxt = c_st_full;
                end else if (w_pop && !w_push && (r_level == c_lvl_one)) begin
                    w_state_nxt = c_st_empty;
                end
            end
            c_st_full: begin
                // No push is possible while full; DEPTH >= 2 means one pop
                // always lands in PARTIAL.
                if (w_pop) begin
                    w_state_nxt = c_st_partial;
                end
            end
            default: begin
                w_state_nxt = c_st_empty;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pointers, level and error tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_err_pulse <= 1'b0;
            r_err_count <= 8'h00;
        end else begin
            r_level     <= w_level_nxt;
            r_err_pulse <= w_reject;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_reject && (r_err_count != c_err_max)) begin
                r_err_count <= r_err_count + 8'h01;
            end
        end
    end

    // Storage is deliberately left unreset; emptiness is tracked by the
    // pointers/level and the output is masked while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_word  = w_out_valid ? r_mem[r_rd_ptr] : 16'h0000;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;
    assign level     = r_level;

    // Unused-bit guard: c_lvl_depth documents the full level and keeps the
    // full-state relation explicit for readers.
    logic w_level_is_full;
    assign w_level_is_full = (r_level == c_lvl_depth);
    logic w_unused;
    assign w_unused = w_level_is_full;

endmodule
`default_nettype wire

// File: tb/tb_instr_field_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_field_encoder
// Purpose  : Self-checking bench for instr_field_encoder. A queue-based
//            reference model tracks the buffered words and error counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_field_encoder;

    localparam int DEPTH = 4;
    localparam int LVLW  = 3;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_op;
    logic [3:0]      in_ra;
    logic [3:0]      in_rb;
    logic [3:0]      in_rc;
    logic            in_flag;
    logic            out_valid;
    logic            out_ready;
    logic [15:0]     out_word;
    logic            err_pulse;
    logic [7:0]      err_count;
    logic [LVLW-1:0] level;

    int checks;
    int errors;

    // Reference model state
    logic [15:0] mq[$];
    int          m_cnt;
    logic        m_pulse;

    instr_field_encoder #(.DEPTH(DEPTH), .LVLW(LVLW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_ra     (in_ra),
        .in_rb     (in_rb),
        .in_rc     (in_rc),
        .in_flag   (in_flag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_all();
        chk("in_ready",  {15'd0, in_ready},  {15'd0, (mq.size() < DEPTH)});
        chk("out_valid", {15'd0, out_valid}, {15'd0, (mq.size() != 0)});
        chk("level",     {13'd0, level},     16'(mq.size()));
        chk("err_pulse", {15'd0, err_pulse}, {15'd0, m_pulse});
        chk("err_count", {8'd0, err_count},  16'(m_cnt));
        if (mq.size() != 0) begin
            chk("out_word", out_word, mq[0]);
        end
    endtask

    // One clock cycle with the given inputs; model updated from the
    // pre-edge occupancy, then all outputs compared after the edge.
    task automatic step(input logic v, input logic [3:0] op, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [3:0] rc,
                        input logic fl, input logic ordy);
        logic acc;
        logic pop;
        logic rej;
        in_valid  = v;
        in_op     = op;
        in_ra     = ra;
        in_rb     = rb;
        in_rc     = rc;
        in_flag   = fl;
        out_ready = ordy;
        acc = v && (mq.size() < DEPTH);
        pop = (mq.size() != 0) && ordy;
        rej = acc && (fl != rc[2]);
        @(posedge clk);
        #1;
        if (pop) void'(mq.pop_front());
        if (acc && !rej) mq.push_back({op, ra, rb, rc});
        m_pulse = rej;
        if (rej && m_cnt < 255) m_cnt++;
        check_all();
    endtask

    task automatic push_word(input logic [15:0] w, input logic ordy);
        step(1'b1, w[15:12], w[11:8], w[7:4], w[3:0], w[2], ordy);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, ordy);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        m_cnt   = 0;
        m_pulse = 1'b0;
        check_all();
        chk("rst_out_word", out_word, 16'h0000);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        m_cnt     = 0;
        m_pulse   = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 4'h0;
        in_ra     = 4'h0;
        in_rb     = 4'h0;
        in_rc     = 4'h0;
        in_flag   = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        do_reset();

        // Single set 3333
        step(1'b1, 4'h3, 4'h3, 4'h3, 4'h3, 1'b0, 1'b1);
        chk("single_word", out_word, 16'h3333);
        chk("single_valid", {15'd0, out_valid}, 16'd1);
        idle(1'b1);
        chk("single_drained", {13'd0, level}, 16'd0);

        // Flag mismatch then matching set
        step(1'b1, 4'h3, 4'h3, 4'h3, 4'h3, 1'b1, 1'b1);
        chk("mis_pulse", {15'd0, err_pulse}, 16'd1);
        chk("mis_count", {8'd0, err_count}, 16'd1);
        step(1'b1, 4'h3, 4'h3, 4'h3, 4'h4, 1'b1, 1'b0);
        chk("mis_pulse_off", {15'd0, err_pulse}, 16'd0);
        chk("after_mis_word", out_word, 16'h3334);
        idle(1'b1);

        // Fill and backpressure
        push_word(16'h1000, 1'b0);
        push_word(16'h2001, 1'b0);
        push_word(16'h3002, 1'b0);
        push_word(16'h4003, 1'b0);
        chk("full_ready", {15'd0, in_ready}, 16'd0);
        push_word(16'h5004, 1'b0);            // held, not taken
        push_word(16'h5004, 1'b1);            // pop, still not taken
        chk("pop_at_full_level", {13'd0, level}, 16'd3);
        push_word(16'h5004, 1'b0);            // accepted now
        chk("refill_level", {13'd0, level}, 16'd4);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Simultaneous push/pop at level 2
        push_word(16'h0100, 1'b0);
        push_word(16'h0101, 1'b0);
        for (int i = 0; i < 10; i++) begin
            push_word(16'h0102 + 16'(i), 1'b1);
            chk("pp_level", {13'd0, level}, 16'd2);
        end
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Saturation
        for (int i = 0; i < 260; i++) step(1'b1, 4'h1, 4'h2, 4'h3, 4'h0, 1'b1, 1'b1);
        chk("sat_count", {8'd0, err_count}, 16'h00FF);
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [15:0] w;
            logic        fl;
            w  = 16'($urandom);
            fl = w[2] ^ ($urandom_range(0, 7) == 0);
            step(1'($urandom_range(0, 3) != 0), w[15:12], w[11:8], w[7:4], w[3:0],
                 fl, 1'($urandom_range(0, 2) != 0));
        end

        // Reset mid-operation
        do_reset();
        push_word(16'hA001, 1'b0);
        push_word(16'hA002, 1'b0);
        push_word(16'hA003, 1'b0);
        chk("pre_rst_level", {13'd0, level}, 16'd3);
        do_reset();
        push_word(16'hB00C, 1'b0);
        chk("post_rst_first", out_word, 16'hB00C);
        idle(1'b1);
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
